qrs_adaptive_detector: RTL

- Streaming, clocked successor to the combinational adaptive-threshold QRS decision.
- Consumes one wavelet-domain modulus/MPavg sample per valid cycle.
- Keeps a ring of the last NPEAK detected peak amplitudes; the adaptive threshold is the ring mean plus BIAS.
- Adds what the combinational block lacks: peak tracking, refractory blanking, search-back threshold lowering and a peak-width timeout. It emits one pulse per detected QRS complex to downstream R-R logic.

---
 rtl/qrs_pkg.sv | 28 ++
 rtl/qrs_adaptive_detector_if.sv | 28 ++
 rtl/qrs_peak_ring.sv | 37 +++
 rtl/qrs_adaptive_detector.sv | 128 ++++++++++++
 4 files changed

// File: rtl/qrs_pkg.sv
// Shared types and helpers for the streaming adaptive-threshold QRS detector.
package qrs_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_PEAK    = 2'd1,
    ST_REFRACT = 2'd2
  } qrs_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Unsigned add clamped to max_v; operands are zero-extended by the caller.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_v);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max_v}) ? max_v : s[31:0];
  endfunction

endpackage

// File: rtl/qrs_adaptive_detector_if.sv
// Sample-in / detection-out bundle for qrs_adaptive_detector.
// Handshake: no back-pressure; every cycle with in_valid=1 consumes in_data, and
// qrs_valid is a one-cycle pulse that qualifies qrs_amp and qrs_searchback.
interface qrs_adaptive_detector_if
  import qrs_pkg::*;
#(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] init_level;
  logic              qrs_valid;
  logic [DATA_W-1:0] qrs_amp;
  logic              qrs_searchback;
  logic [DATA_W-1:0] threshold;
  logic              sb_active;
  qrs_state_t        dbg_state;

  modport master (
    output in_valid, in_data, init_level,
    input  qrs_valid, qrs_amp, qrs_searchback, threshold, sb_active, dbg_state
  );

  modport slave (
    input  in_valid, in_data, init_level,
    output qrs_valid, qrs_amp, qrs_searchback, threshold, sb_active, dbg_state
  );
endinterface

// File: rtl/qrs_peak_ring.sv
// Ring of the last NPEAK detected peak amplitudes with a running sum and mean.
module qrs_peak_ring
  import qrs_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NPEAK  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] init_level,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] mean
);
  localparam int LOG   = clog2(NPEAK);
  localparam int SUM_W = DATA_W + LOG;

  logic [DATA_W-1:0] r_ring [NPEAK];
  logic [SUM_W-1:0]  r_sum;
  logic [LOG-1:0]    r_ptr;

  // The sum is kept exact, so the mean is a plain shift with no divider.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NPEAK; i++) r_ring[i] <= init_level;
      r_sum <= SUM_W'(init_level) << LOG;
      r_ptr <= '0;
    end else if (push) begin
      r_sum         <= r_sum - SUM_W'(r_ring[r_ptr]) + SUM_W'(push_data);
      r_ring[r_ptr] <= push_data;
      r_ptr         <= r_ptr + LOG'(1);
    end
  end

  assign mean = r_sum[SUM_W-1:LOG];

endmodule

// File: rtl/qrs_adaptive_detector.sv
// Streaming QRS detector: adaptive ring-mean threshold, peak tracking,
// refractory blanking, search-back threshold halving and peak-width timeout.
module qrs_adaptive_detector
  import qrs_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NPEAK    = 4,
  parameter int BIAS     = 8,
  parameter int REFRACT  = 50,
  parameter int SB_LIMIT = 300,
  parameter int MAXW     = 40,
  parameter int CNT_W    = 12
) (
  input logic                    clk,
  input logic                    rst,
  qrs_adaptive_detector_if.slave bus
);
  localparam logic [DATA_W-1:0] DATA_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
  localparam logic [CNT_W-1:0]  L_REFRACT  = CNT_W'(REFRACT);
  localparam logic [CNT_W-1:0]  L_SB_LIMIT = CNT_W'(SB_LIMIT);
  localparam logic [CNT_W-1:0]  L_MAXW     = CNT_W'(MAXW);

  qrs_state_t        r_state;
  logic [CNT_W-1:0]  r_since;
  logic [CNT_W-1:0]  r_refr;
  logic [CNT_W-1:0]  r_len;
  logic [DATA_W-1:0] r_max;
  logic [DATA_W-1:0] r_thr_lat;
  logic              r_pk_sb;
  logic              r_sb;
  logic              r_qv;
  logic [DATA_W-1:0] r_qamp;
  logic              r_qsb;

  logic [DATA_W-1:0] w_mean;
  logic [DATA_W-1:0] w_lambda1;
  logic [DATA_W-1:0] w_threshold;
  logic [DATA_W-1:0] w_new_max;
  logic [CNT_W-1:0]  w_len_next;
  logic [CNT_W-1:0]  w_since_inc;
  logic [CNT_W-1:0]  w_refr_inc;
  logic              w_peak_end;

  qrs_peak_ring #(
    .DATA_W(DATA_W),
    .NPEAK (NPEAK)
  ) u_ring (
    .clk       (clk),
    .rst       (rst),
    .init_level(bus.init_level),
    .push      (w_peak_end),
    .push_data (w_new_max),
    .mean      (w_mean)
  );

  assign w_lambda1   = DATA_W'(sat_add(32'(w_mean), 32'(BIAS), 32'(DATA_MAX)));
  assign w_threshold = r_sb ? (w_lambda1 >> 1) : w_lambda1;

  assign w_new_max   = (bus.in_data > r_max) ? bus.in_data : r_max;
  assign w_len_next  = r_len + CNT_W'(1);
  assign w_since_inc = (r_since == CNT_MAX) ? r_since : r_since + CNT_W'(1);
  assign w_refr_inc  = r_refr + CNT_W'(1);
  // The ending sample itself still contributes to the peak maximum.
  assign w_peak_end  = bus.in_valid && (r_state == ST_PEAK) &&
                       ((bus.in_data <= r_thr_lat) || (w_len_next >= L_MAXW));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_SEARCH;
      r_since   <= '0;
      r_refr    <= '0;
      r_len     <= '0;
      r_max     <= '0;
      r_thr_lat <= '0;
      r_pk_sb   <= 1'b0;
      r_sb      <= 1'b0;
      r_qv      <= 1'b0;
      r_qamp    <= '0;
      r_qsb     <= 1'b0;
    end else begin
      r_qv <= 1'b0;
      if (bus.in_valid) begin
        case (r_state)
          ST_SEARCH: begin
            if (bus.in_data > w_threshold) begin
              r_state   <= ST_PEAK;
              r_max     <= bus.in_data;
              r_thr_lat <= w_threshold;
              r_pk_sb   <= r_sb;
              r_len     <= CNT_W'(1);
            end else begin
              r_since <= w_since_inc;
              if (w_since_inc >= L_SB_LIMIT) r_sb <= 1'b1;
            end
          end
          ST_PEAK: begin
            r_max <= w_new_max;
            r_len <= w_len_next;
            if (w_peak_end) begin
              r_qv    <= 1'b1;
              r_qamp  <= w_new_max;
              r_qsb   <= r_pk_sb;
              r_sb    <= 1'b0;
              r_since <= '0;
              r_refr  <= '0;
              r_state <= ST_REFRACT;
            end
          end
          ST_REFRACT: begin
            r_refr  <= w_refr_inc;
            r_since <= w_since_inc;
            if (w_refr_inc >= L_REFRACT) r_state <= ST_SEARCH;
          end
          default: r_state <= ST_SEARCH;
        endcase
      end
    end
  end

  assign bus.qrs_valid      = r_qv;
  assign bus.qrs_amp        = r_qamp;
  assign bus.qrs_searchback = r_qsb;
  assign bus.threshold      = w_threshold;
  assign bus.sb_active      = r_sb;
  assign bus.dbg_state      = r_state;

endmodule
